// File: rtl/register_file_pkg.sv
// Shared types for the RV32 integer register file: register names, the
// writeback write bundle and a read address/data pair used by decode.
package register_file_pkg;

  localparam int REGISTER_COUNT = 32;
  localparam int XLEN = 32;

  typedef enum logic [4:0] {
    X0,  X1,  X2,  X3,  X4,  X5,  X6,  X7,
    X8,  X9,  X10, X11, X12, X13, X14, X15,
    X16, X17, X18, X19, X20, X21, X22, X23,
    X24, X25, X26, X27, X28, X29, X30, X31
  } register_e;

  typedef struct packed {
    logic            enable;
    register_e       address;
    logic [XLEN-1:0] data;
  } register_file_write_t;

  typedef struct packed {
    register_e       address;
    logic [XLEN-1:0] data;
  } register_file_read_t;

endpackage

// File: rtl/register_file_scoreboard.sv
// Pending-write scoreboard: one busy flag per register, set by decode
// reservations, cleared by writeback, wiped by flush.
module register_scoreboard
  import register_file_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  register_file_write_t write_i,
  input  logic                 reserve_enable_i,
  input  register_e            reserve_address_i,
  input  logic                 flush_i,
  input  register_e            rs1_address_i,
  input  register_e            rs2_address_i,
  output logic                 rs1_busy_o,
  output logic                 rs2_busy_o
);

  // Bit 0 exists only so x0 can be indexed; it is never set.
  logic [REGISTER_COUNT-1:0] busy_q;
  logic [REGISTER_COUNT-1:0] busy_d;

  always_comb begin
    busy_d = busy_q;
    if (write_i.enable && write_i.address != X0) begin
      busy_d[write_i.address] = 1'b0;
    end
    // Reservation is applied after the clear: it belongs to the younger instruction.
    if (flush_i) begin
      busy_d = '0;
    end else if (reserve_enable_i && reserve_address_i != X0) begin
      busy_d[reserve_address_i] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  function automatic logic port_busy(register_e addr);
    if (addr == X0) begin
      return 1'b0;
    end
    return busy_q[addr] & ~(write_i.enable && write_i.address == addr);
  endfunction

  always_comb begin
    rs1_busy_o = port_busy(rs1_address_i);
    rs2_busy_o = port_busy(rs2_address_i);
  end

endmodule

// File: rtl/register_file.sv
// RV32 architectural register file: x1..x31 storage, x0 hardwired to zero,
// combinational reads with same-cycle write bypass, plus hazard scoreboard.
module register_file #(
  parameter int REGISTER_COUNT = register_file_pkg::REGISTER_COUNT
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  input  register_file_pkg::register_file_write_t write_i,
  input  register_file_pkg::register_e            rs1_address_i,
  input  register_file_pkg::register_e            rs2_address_i,
  output logic [31:0]                             rs1_data_o,
  output logic [31:0]                             rs2_data_o,
  input  logic                                    reserve_enable_i,
  input  register_file_pkg::register_e            reserve_address_i,
  input  logic                                    flush_i,
  output logic                                    rs1_busy_o,
  output logic                                    rs2_busy_o
);

  import register_file_pkg::*;

  logic [31:0] regs_q [1:REGISTER_COUNT-1];
  logic [31:0] regs_d [1:REGISTER_COUNT-1];

  always_comb begin
    regs_d = regs_q;
    if (write_i.enable && write_i.address != X0) begin
      regs_d[write_i.address] = write_i.data;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 1; i < REGISTER_COUNT; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Bypass lets decode see a writeback result in the cycle it is presented.
  function automatic logic [31:0] read_port(register_e addr);
    if (addr == X0) begin
      return '0;
    end
    if (write_i.enable && write_i.address == addr) begin
      return write_i.data;
    end
    return regs_q[addr];
  endfunction

  always_comb begin
    rs1_data_o = read_port(rs1_address_i);
    rs2_data_o = read_port(rs2_address_i);
  end

  register_scoreboard u_scoreboard (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .write_i           (write_i),
    .reserve_enable_i  (reserve_enable_i),
    .reserve_address_i (reserve_address_i),
    .flush_i           (flush_i),
    .rs1_address_i     (rs1_address_i),
    .rs2_address_i     (rs2_address_i),
    .rs1_busy_o        (rs1_busy_o),
    .rs2_busy_o        (rs2_busy_o)
  );

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: reset, x0, bypass, scoreboard, flush.
module tb_register_file;
  import register_file_pkg::*;

  logic                 clk_i = 1'b0;
  logic                 rst_i;
  register_file_write_t write_i;
  register_e            rs1_address_i;
  register_e            rs2_address_i;
  logic [31:0]          rs1_data_o;
  logic [31:0]          rs2_data_o;
  logic                 reserve_enable_i;
  register_e            reserve_address_i;
  logic                 flush_i;
  logic                 rs1_busy_o;
  logic                 rs2_busy_o;

  int checks = 0;
  int errors = 0;

  register_file dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .write_i           (write_i),
    .rs1_address_i     (rs1_address_i),
    .rs2_address_i     (rs2_address_i),
    .rs1_data_o        (rs1_data_o),
    .rs2_data_o        (rs2_data_o),
    .reserve_enable_i  (reserve_enable_i),
    .reserve_address_i (reserve_address_i),
    .flush_i           (flush_i),
    .rs1_busy_o        (rs1_busy_o),
    .rs2_busy_o        (rs2_busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Inputs change 1 time unit after the rising edge; checks happen 1 unit later.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    write_i          = '0;
    reserve_enable_i = 1'b0;
    reserve_address_i = X0;
    flush_i          = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    idle();
    rs1_address_i = X5;
    rs2_address_i = X5;
    #2;
    checks++;
    if (rs1_data_o !== 32'h0) begin errors++; $display("FAIL reset_init_data got %h want %h", rs1_data_o, 32'h0); end
    checks++;
    if (rs1_busy_o !== 1'b0) begin errors++; $display("FAIL reset_init_busy got %b want 0", rs1_busy_o); end
    tick();
    rst_i = 1'b0;
    write_i = '{enable: 1'b1, address: X5, data: 32'h1234};
    reserve_enable_i = 1'b1;
    reserve_address_i = X5;
    tick();
    idle();
    #1;
    checks++;
    if (rs1_data_o !== 32'h1234) begin errors++; $display("FAIL reset_x5_written got %h want %h", rs1_data_o, 32'h1234); end
    checks++;
    if (rs1_busy_o !== 1'b1) begin errors++; $display("FAIL reset_x5_busy_before got %b want 1", rs1_busy_o); end
    #1;
    rst_i = 1'b1;
    #1;
    checks++;
    if (rs1_data_o !== 32'h0) begin errors++; $display("FAIL reset_async_data got %h want %h", rs1_data_o, 32'h0); end
    checks++;
    if (rs1_busy_o !== 1'b0) begin errors++; $display("FAIL reset_async_busy got %b want 0", rs1_busy_o); end
    tick();
    rst_i = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_x0();
    write_i = '{enable: 1'b1, address: X0, data: 32'hFFFF_FFFF};
    rs1_address_i = X0;
    rs2_address_i = X0;
    #1;
    checks++;
    if (rs1_data_o !== 32'h0) begin errors++; $display("FAIL x0_bypass_rs1 got %h want 0", rs1_data_o); end
    tick();
    idle();
    reserve_enable_i = 1'b1;
    reserve_address_i = X0;
    #1;
    checks++;
    if (rs2_data_o !== 32'h0) begin errors++; $display("FAIL x0_stored_rs2 got %h want 0", rs2_data_o); end
    tick();
    idle();
    #1;
    checks++;
    if ({rs1_busy_o, rs2_busy_o} !== 2'b00) begin errors++; $display("FAIL x0_busy got %b want 00", {rs1_busy_o, rs2_busy_o}); end
    $display("test_x0 done");
  endtask

  task automatic test_bypass();
    write_i = '{enable: 1'b1, address: X7, data: 32'hDEAD_BEEF};
    rs1_address_i = X7;
    rs2_address_i = X7;
    #1;
    checks++;
    if (rs1_data_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL bypass_rs1 got %h want %h", rs1_data_o, 32'hDEAD_BEEF); end
    checks++;
    if (rs2_data_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL bypass_rs2 got %h want %h", rs2_data_o, 32'hDEAD_BEEF); end
    tick();
    idle();
    #1;
    checks++;
    if (rs1_data_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL stored_rs1 got %h want %h", rs1_data_o, 32'hDEAD_BEEF); end
    checks++;
    if (rs2_data_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL stored_rs2 got %h want %h", rs2_data_o, 32'hDEAD_BEEF); end
    $display("test_bypass done");
  endtask

  task automatic test_scoreboard();
    rs1_address_i = X3;
    rs2_address_i = X7;
    reserve_enable_i = 1'b1;
    reserve_address_i = X3;
    #1;
    checks++;
    if (rs1_busy_o !== 1'b0) begin errors++; $display("FAIL sb_before_edge got %b want 0", rs1_busy_o); end
    tick();
    idle();
    #1;
    checks++;
    if (rs1_busy_o !== 1'b1) begin errors++; $display("FAIL sb_reserved got %b want 1", rs1_busy_o); end
    checks++;
    if (rs2_busy_o !== 1'b0) begin errors++; $display("FAIL sb_other_reg got %b want 0", rs2_busy_o); end
    write_i = '{enable: 1'b1, address: X3, data: 32'h42};
    #1;
    checks++;
    if (rs1_busy_o !== 1'b0) begin errors++; $display("FAIL sb_write_hides_busy got %b want 0", rs1_busy_o); end
    checks++;
    if (rs1_data_o !== 32'h42) begin errors++; $display("FAIL sb_write_data got %h want %h", rs1_data_o, 32'h42); end
    tick();
    idle();
    #1;
    checks++;
    if (rs1_busy_o !== 1'b0) begin errors++; $display("FAIL sb_cleared got %b want 0", rs1_busy_o); end
    checks++;
    if (rs1_data_o !== 32'h42) begin errors++; $display("FAIL sb_stored got %h want %h", rs1_data_o, 32'h42); end
    $display("test_scoreboard done");
  endtask

  task automatic test_reserve_and_write();
    rs1_address_i = X9;
    rs2_address_i = X9;
    reserve_enable_i = 1'b1;
    reserve_address_i = X9;
    tick();
    write_i = '{enable: 1'b1, address: X9, data: 32'h0000_0099};
    #1;
    checks++;
    if (rs2_busy_o !== 1'b0) begin errors++; $display("FAIL rw_busy_during_write got %b want 0", rs2_busy_o); end
    tick();
    idle();
    #1;
    checks++;
    if (rs1_busy_o !== 1'b1) begin errors++; $display("FAIL rw_busy_after got %b want 1", rs1_busy_o); end
    checks++;
    if (rs1_data_o !== 32'h99) begin errors++; $display("FAIL rw_data_after got %h want %h", rs1_data_o, 32'h99); end
    $display("test_reserve_and_write done");
  endtask

  task automatic test_flush();
    reserve_enable_i = 1'b1;
    reserve_address_i = X4;
    tick();
    reserve_address_i = X6;
    tick();
    idle();
    rs1_address_i = X4;
    rs2_address_i = X6;
    #1;
    checks++;
    if ({rs1_busy_o, rs2_busy_o} !== 2'b11) begin errors++; $display("FAIL flush_pre_busy got %b want 11", {rs1_busy_o, rs2_busy_o}); end
    flush_i = 1'b1;
    reserve_enable_i = 1'b1;
    reserve_address_i = X8;
    write_i = '{enable: 1'b1, address: X10, data: 32'h77};
    tick();
    idle();
    #1;
    checks++;
    if ({rs1_busy_o, rs2_busy_o} !== 2'b00) begin errors++; $display("FAIL flush_x4_x6 got %b want 00", {rs1_busy_o, rs2_busy_o}); end
    rs1_address_i = X8;
    rs2_address_i = X10;
    #1;
    checks++;
    if (rs1_busy_o !== 1'b0) begin errors++; $display("FAIL flush_x8 got %b want 0", rs1_busy_o); end
    checks++;
    if (rs2_data_o !== 32'h77) begin errors++; $display("FAIL flush_write_kept got %h want %h", rs2_data_o, 32'h77); end
    checks++;
    if (rs2_busy_o !== 1'b0) begin errors++; $display("FAIL flush_x10_busy got %b want 0", rs2_busy_o); end
    $display("test_flush done");
  endtask

  initial begin
    test_reset();
    test_x0();
    test_bypass();
    test_scoreboard();
    test_reserve_and_write();
    test_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
